// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the N-master to 1-slave bus arbiter.
// Imported by the arbiter top and its response-routing FIFO.
package bus_arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_resp_fifo.sv
// Index FIFO remembering which master issued each accepted transaction,
// so responses can be steered back in order.
module bus_resp_fifo
    import bus_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = idx_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: only entries between the pointers are read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/bus_arbiter_nm1s.sv
// N-master to 1-slave req/gnt/rvalid arbiter with address-window
// qualification, stall lock and in-order response routing.
module bus_arbiter_nm1s
    import bus_arb_pkg::*;
#(
    parameter int                    NUM_MASTERS     = 2,
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] SLAVE_START     = '0,
    parameter logic [ADDR_WIDTH-1:0] SLAVE_SIZE      = 'h8000,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter int                    ROUND_ROBIN     = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_MASTERS-1:0]            m_req_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_be_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
    output logic [NUM_MASTERS-1:0]            m_gnt_o,
    output logic [NUM_MASTERS-1:0]            m_rvalid_o,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic                              s_req_o,
    output logic [ADDR_WIDTH-1:0]             s_addr_o,
    output logic                              s_we_o,
    output logic [DATA_WIDTH/8-1:0]           s_be_o,
    output logic [DATA_WIDTH-1:0]             s_wdata_o,
    input  logic                              s_gnt_i,
    input  logic                              s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]             s_rdata_i,
    input  logic                              s_err_i,
    output logic                              busy_o
);

    localparam int        IDX_W = idx_width(NUM_MASTERS);
    localparam int        BE_W  = DATA_WIDTH / 8;
    localparam arb_mode_e MODE  = (ROUND_ROBIN != 0) ? ARB_RR : ARB_FIXED;
    localparam logic [ADDR_WIDTH-1:0] WIN_MASK =
        ~(SLAVE_SIZE - ADDR_WIDTH'(1));

    logic [NUM_MASTERS-1:0] elig;
    logic [IDX_W-1:0]       winner;
    logic [IDX_W-1:0]       cand;
    logic                   any_elig;
    logic [IDX_W-1:0]       rr_ptr_q;
    logic                   lock_q;
    logic [IDX_W-1:0]       lock_idx_q;
    logic                   full;
    logic                   empty;
    logic [IDX_W-1:0]       head;
    logic                   accept;
    logic                   pop;
    logic                   stall;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            elig[i] = m_req_i[i] &&
                ((m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] & WIN_MASK)
                 == SLAVE_START);
        end
    end

    // Round-robin scans downwards so the first index in search order
    // is the last one written.
    always_comb begin
        winner   = '0;
        cand     = '0;
        any_elig = 1'b0;
        if (MODE == ARB_FIXED) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (elig[i]) begin
                    winner   = IDX_W'(i);
                    any_elig = 1'b1;
                end
            end
        end else begin
            for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
                cand = IDX_W'((int'(rr_ptr_q) + 1 + k) % NUM_MASTERS);
                if (elig[cand]) begin
                    winner   = cand;
                    any_elig = 1'b1;
                end
            end
        end
        if (lock_q && elig[lock_idx_q]) begin
            winner   = lock_idx_q;
            any_elig = 1'b1;
        end
    end

    assign s_req_o = rst_ni & any_elig & ~full;
    assign accept  = s_req_o & s_gnt_i;
    assign stall   = s_req_o & ~s_gnt_i;
    assign pop     = rst_ni & s_rvalid_i & ~empty;
    assign busy_o  = ~empty;

    always_comb begin
        s_addr_o  = '0;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_wdata_o = '0;
        m_gnt_o   = '0;
        if (s_req_o) begin
            s_addr_o  = m_addr_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            s_we_o    = m_we_i[winner];
            s_be_o    = m_be_i[int'(winner)*BE_W +: BE_W];
            s_wdata_o = m_wdata_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            m_gnt_o[winner] = s_gnt_i;
        end
    end

    always_comb begin
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        m_err_o    = '0;
        if (pop) begin
            m_rvalid_o[head] = 1'b1;
            m_rdata_o[int'(head)*DATA_WIDTH +: DATA_WIDTH] = s_rdata_i;
            m_err_o[head] = s_err_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q <= stall;
            if (stall) begin
                lock_idx_q <= winner;
            end
            if (accept) begin
                rr_ptr_q <= winner;
            end
        end
    end

    bus_resp_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (accept),
        .pop_i   (pop),
        .data_i  (winner),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule

// File: tb/tb_bus_arbiter_nm1s.sv
// Directed bench: a 4-master round-robin arbiter and a 4-master
// fixed-priority arbiter share one set of stimulus signals.
module tb_bus_arbiter_nm1s;

    logic         clk;
    logic         rst_n;
    logic [3:0]   m_req;
    logic [127:0] m_addr;
    logic [3:0]   m_we;
    logic [15:0]  m_be;
    logic [127:0] m_wdata;
    logic         s_gnt;
    logic         s_rvalid;
    logic [31:0]  s_rdata;
    logic         s_err;

    logic [3:0]   r_gnt, r_rvalid, r_err, r_sbe;
    logic [127:0] r_rdata;
    logic         r_sreq, r_swe, r_busy;
    logic [31:0]  r_saddr, r_swdata;

    logic [3:0]   f_gnt, f_rvalid, f_err, f_sbe;
    logic [127:0] f_rdata;
    logic         f_sreq, f_swe, f_busy;
    logic [31:0]  f_saddr, f_swdata;

    int checks = 0;
    int errors = 0;

    bus_arbiter_nm1s #(.NUM_MASTERS(4), .ROUND_ROBIN(1)) u_rr (
        .clk_i(clk), .rst_ni(rst_n),
        .m_req_i(m_req), .m_addr_i(m_addr), .m_we_i(m_we),
        .m_be_i(m_be), .m_wdata_i(m_wdata),
        .m_gnt_o(r_gnt), .m_rvalid_o(r_rvalid),
        .m_rdata_o(r_rdata), .m_err_o(r_err),
        .s_req_o(r_sreq), .s_addr_o(r_saddr), .s_we_o(r_swe),
        .s_be_o(r_sbe), .s_wdata_o(r_swdata),
        .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid),
        .s_rdata_i(s_rdata), .s_err_i(s_err),
        .busy_o(r_busy)
    );

    bus_arbiter_nm1s #(.NUM_MASTERS(4), .ROUND_ROBIN(0)) u_fx (
        .clk_i(clk), .rst_ni(rst_n),
        .m_req_i(m_req), .m_addr_i(m_addr), .m_we_i(m_we),
        .m_be_i(m_be), .m_wdata_i(m_wdata),
        .m_gnt_o(f_gnt), .m_rvalid_o(f_rvalid),
        .m_rdata_o(f_rdata), .m_err_o(f_err),
        .s_req_o(f_sreq), .s_addr_o(f_saddr), .s_we_o(f_swe),
        .s_be_o(f_sbe), .s_wdata_o(f_swdata),
        .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid),
        .s_rdata_i(s_rdata), .s_err_i(s_err),
        .busy_o(f_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] addr_of(input int i);
        return 32'h1000 + 32'(i * 4);
    endfunction

    function automatic logic [31:0] wdata_of(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    task automatic set_defaults();
        for (int i = 0; i < 4; i++) begin
            m_addr[i*32 +: 32]  = addr_of(i);
            m_wdata[i*32 +: 32] = wdata_of(i);
        end
        m_we     = 4'b0101;
        m_be     = 16'hFFFF;
        m_req    = '0;
        s_gnt    = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = '0;
        s_err    = 1'b0;
    endtask

    task automatic do_reset();
        set_defaults();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_defaults();
        rst_n    = 1'b0;
        m_req    = 4'hF;
        s_gnt    = 1'b1;
        s_rvalid = 1'b1;
        s_rdata  = 32'hDEAD_BEEF;
        s_err    = 1'b1;
        #1;
        checks++;
        if (r_sreq !== 1'b0 || r_gnt !== 4'b0) begin
            errors++;
            $display("FAIL reset_req got sreq=%b gnt=%b exp 0/0000",
                     r_sreq, r_gnt);
        end
        checks++;
        if (r_busy !== 1'b0 || r_rvalid !== 4'b0 || r_err !== 4'b0) begin
            errors++;
            $display("FAIL reset_rsp got busy=%b rvalid=%b err=%b exp 0",
                     r_busy, r_rvalid, r_err);
        end
        checks++;
        if (f_sreq !== 1'b0 || f_saddr !== 32'h0 || f_rdata !== 128'h0) begin
            errors++;
            $display("FAIL reset_fx got sreq=%b addr=%h exp 0/0",
                     f_sreq, f_saddr);
        end
        do_reset();
    endtask

    task automatic test_rr_order();
        logic [3:0] exp;
        int w;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            m_req    = 4'hF;
            s_gnt    = 1'b1;
            s_rvalid = (c > 0);
            s_rdata  = 32'hD000_0000 + 32'(c);
            @(negedge clk);
            w   = (c + 1) % 4;
            exp = 4'b0001 << w;
            checks++;
            if (r_gnt !== exp || r_saddr !== addr_of(w)) begin
                errors++;
                $display("FAIL rr_gnt c=%0d got %b/%h exp %b/%h",
                         c, r_gnt, r_saddr, exp, addr_of(w));
            end
            checks++;
            if (r_swdata !== wdata_of(w) || r_swe !== ((w % 2) == 0)) begin
                errors++;
                $display("FAIL rr_wdata c=%0d got %h/%b exp %h",
                         c, r_swdata, r_swe, wdata_of(w));
            end
            if (c > 0) begin
                checks++;
                if (r_rvalid !== (4'b0001 << (c % 4)) ||
                    r_rdata[(c%4)*32 +: 32] !== 32'hD000_0000 + 32'(c)) begin
                    errors++;
                    $display("FAIL rr_route c=%0d got %b/%h exp %b/%h",
                             c, r_rvalid, r_rdata[(c%4)*32 +: 32],
                             4'b0001 << (c % 4), 32'hD000_0000 + 32'(c));
                end
            end
        end
        @(posedge clk);
        #1;
        m_req    = '0;
        s_gnt    = 1'b0;
        s_rvalid = 1'b1;
        s_rdata  = 32'hE0E0_0000;
        @(negedge clk);
        checks++;
        if (r_rvalid !== 4'b0001 || r_rdata[31:0] !== 32'hE0E0_0000) begin
            errors++;
            $display("FAIL rr_drain got %b/%h exp 0001/e0e00000",
                     r_rvalid, r_rdata[31:0]);
        end
        @(posedge clk);
        #1 s_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (r_busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle got busy=%b exp 0", r_busy);
        end
    endtask

    task automatic test_fixed();
        logic [3:0] req_v [4];
        logic [3:0] gnt_v [4];
        logic [3:0] rv_v  [4];
        req_v = '{4'b1010, 4'b1010, 4'b0010, 4'b0000};
        gnt_v = '{4'b1000, 4'b1000, 4'b0010, 4'b0000};
        rv_v  = '{4'b0000, 4'b1000, 4'b1000, 4'b0010};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            m_req    = req_v[c];
            s_gnt    = 1'b1;
            s_rvalid = (c > 0);
            s_rdata  = 32'hF000_0000 + 32'(c);
            @(negedge clk);
            checks++;
            if (f_gnt !== gnt_v[c] || f_rvalid !== rv_v[c]) begin
                errors++;
                $display("FAIL fixed c=%0d got gnt=%b rv=%b exp %b/%b",
                         c, f_gnt, f_rvalid, gnt_v[c], rv_v[c]);
            end
        end
        @(posedge clk);
        #1;
        s_rvalid = 1'b0;
        s_gnt    = 1'b0;
        @(negedge clk);
        checks++;
        if (f_busy !== 1'b0 || f_sreq !== 1'b0) begin
            errors++;
            $display("FAIL fixed_idle got busy=%b sreq=%b exp 0/0",
                     f_busy, f_sreq);
        end
    endtask

    task automatic test_lock();
        logic [3:0] req_v [5];
        logic       sg_v  [5];
        logic [3:0] gnt_v [5];
        logic [31:0] ad_v [5];
        req_v = '{4'b0001, 4'b0101, 4'b0101, 4'b0101, 4'b0100};
        sg_v  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        gnt_v = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0100};
        ad_v  = '{addr_of(0), addr_of(0), addr_of(0), addr_of(0),
                  addr_of(2)};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            m_req = req_v[c];
            s_gnt = sg_v[c];
            @(negedge clk);
            checks++;
            if (r_sreq !== 1'b1 || r_gnt !== gnt_v[c] ||
                r_saddr !== ad_v[c]) begin
                errors++;
                $display("FAIL lock_rr c=%0d got %b/%b/%h exp 1/%b/%h",
                         c, r_sreq, r_gnt, r_saddr, gnt_v[c], ad_v[c]);
            end
            checks++;
            if (f_gnt !== gnt_v[c] || f_saddr !== ad_v[c]) begin
                errors++;
                $display("FAIL lock_fx c=%0d got %b/%h exp %b/%h",
                         c, f_gnt, f_saddr, gnt_v[c], ad_v[c]);
            end
        end
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            m_req    = '0;
            s_gnt    = 1'b0;
            s_rvalid = 1'b1;
            s_err    = (c == 1);
            @(negedge clk);
            checks++;
            if (r_rvalid !== (c == 0 ? 4'b0001 : 4'b0100) ||
                r_err !== (c == 0 ? 4'b0000 : 4'b0100)) begin
                errors++;
                $display("FAIL lock_rsp c=%0d got rv=%b err=%b", c,
                         r_rvalid, r_err);
            end
        end
        @(posedge clk);
        #1;
        s_rvalid = 1'b0;
        s_err    = 1'b0;
    endtask

    task automatic test_full();
        logic       req_v [8];
        logic       rv_in [8];
        logic       sreq_v [8];
        logic [3:0] gnt_v [8];
        logic [3:0] rv_v  [8];
        logic       busy_v [8];
        req_v  = '{1, 1, 1, 1, 1, 0, 0, 0};
        rv_in  = '{0, 0, 0, 1, 0, 1, 1, 0};
        sreq_v = '{1, 1, 0, 0, 1, 0, 0, 0};
        gnt_v  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001,
                   4'b0000, 4'b0000, 4'b0000};
        rv_v   = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000,
                   4'b0001, 4'b0001, 4'b0000};
        busy_v = '{0, 1, 1, 1, 1, 1, 1, 0};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            m_req    = {3'b000, req_v[c]};
            s_gnt    = 1'b1;
            s_rvalid = rv_in[c];
            @(negedge clk);
            checks++;
            if (r_sreq !== sreq_v[c] || r_gnt !== gnt_v[c] ||
                r_rvalid !== rv_v[c] || r_busy !== busy_v[c]) begin
                errors++;
                $display("FAIL full c=%0d got %b/%b/%b/%b exp %b/%b/%b/%b",
                         c, r_sreq, r_gnt, r_rvalid, r_busy,
                         sreq_v[c], gnt_v[c], rv_v[c], busy_v[c]);
            end
        end
        @(posedge clk);
        #1;
        s_gnt    = 1'b0;
        s_rvalid = 1'b0;
    endtask

    task automatic test_window();
        do_reset();
        @(posedge clk);
        #1;
        m_addr[63:32] = 32'h0000_9000;
        m_req    = 4'b0010;
        s_gnt    = 1'b1;
        s_rvalid = 1'b1;
        s_rdata  = 32'h5555_AAAA;
        @(negedge clk);
        checks++;
        if (r_sreq !== 1'b0 || r_gnt !== 4'b0 || r_saddr !== 32'h0) begin
            errors++;
            $display("FAIL window_out got %b/%b/%h exp 0/0000/0",
                     r_sreq, r_gnt, r_saddr);
        end
        checks++;
        if (r_rvalid !== 4'b0 || r_rdata !== 128'h0) begin
            errors++;
            $display("FAIL empty_rsp got rv=%b exp 0000", r_rvalid);
        end
        @(posedge clk);
        #1;
        m_addr[63:32] = 32'h0000_7FFC;
        s_gnt    = 1'b0;
        s_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (r_sreq !== 1'b1 || r_saddr !== 32'h7FFC || r_busy !== 1'b0) begin
            errors++;
            $display("FAIL window_edge got %b/%h/%b exp 1/7ffc/0",
                     r_sreq, r_saddr, r_busy);
        end
        @(posedge clk);
        #1;
        m_req         = '0;
        m_addr[63:32] = addr_of(1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            m_req = 4'hF;
            s_gnt = 1'b1;
            @(negedge clk);
            checks++;
            if (r_gnt !== (4'b0010 << c)) begin
                errors++;
                $display("FAIL mid_fill c=%0d got %b exp %b", c, r_gnt,
                         4'b0010 << c);
            end
        end
        @(posedge clk);
        #1;
        m_req = '0;
        s_gnt = 1'b0;
        checks++;
        if (r_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy got %b exp 1", r_busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (r_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_busy got %b exp 0", r_busy);
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        s_rvalid = 1'b1;
        s_rdata  = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (r_rvalid !== 4'b0 || r_busy !== 1'b0) begin
            errors++;
            $display("FAIL late_rsp got rv=%b busy=%b exp 0000/0",
                     r_rvalid, r_busy);
        end
        @(posedge clk);
        #1;
        s_rvalid = 1'b0;
        m_req    = 4'hF;
        s_gnt    = 1'b1;
        @(negedge clk);
        checks++;
        if (r_gnt !== 4'b0010) begin
            errors++;
            $display("FAIL ptr_restart got %b exp 0010", r_gnt);
        end
        @(posedge clk);
        #1;
        m_req    = '0;
        s_gnt    = 1'b0;
        s_rvalid = 1'b1;
        s_rdata  = 32'h0BAD_F00D;
        @(negedge clk);
        checks++;
        if (r_rvalid !== 4'b0010 || r_rdata[63:32] !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL post_rst_rsp got %b/%h exp 0010/0badf00d",
                     r_rvalid, r_rdata[63:32]);
        end
        @(posedge clk);
        #1 s_rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rr_order();
        test_fixed();
        test_lock();
        test_full();
        test_window();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
